// File: rtl/calc_pkg.sv
// Shared constants for the calculator front end: debounce default and the
// bit positions used when the five push-buttons are handled as a vector.
package calc_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;  // 10 ms at 100 MHz

  localparam int NUM_BTN = 5;
  localparam int BTN_C   = 0;
  localparam int BTN_L   = 1;
  localparam int BTN_U   = 2;
  localparam int BTN_R   = 3;
  localparam int BTN_D   = 4;

  localparam int SW_W    = 16;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, consecutive-cycle debounce counter,
// debounced level and a one-cycle pulse on each debounced press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic             st, prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      st   <= 1'b0;
      prev <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      prev <= st;
      // Any return to the current level restarts the qualification window.
      if (s2 == st) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        st  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = st;
  // prev and st both clear on reset, so reset release cannot fake a press.
  assign rise  = st & ~prev;

endmodule

// File: rtl/btn_conditioner.sv
// Board front end: synchronises the switches and debounces the five buttons,
// giving levels for the op-select buttons and press pulses for btnu/btnd.
module btn_conditioner
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btnc_raw,
  input  logic            btnl_raw,
  input  logic            btnu_raw,
  input  logic            btnr_raw,
  input  logic            btnd_raw,
  input  logic [SW_W-1:0] sw_raw,
  output logic            btnc,
  output logic            btnl,
  output logic            btnr,
  output logic            btnu,
  output logic            btnd,
  output logic [SW_W-1:0] sw
);

  logic [NUM_BTN-1:0] raw, lvl, rise;
  logic [SW_W-1:0]    sw_s1, sw_s2;

  always_comb begin
    raw        = '0;
    raw[BTN_C] = btnc_raw;
    raw[BTN_L] = btnl_raw;
    raw[BTN_U] = btnu_raw;
    raw[BTN_R] = btnr_raw;
    raw[BTN_D] = btnd_raw;
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[i]),
      .level(lvl[i]),
      .rise (rise[i])
    );
  end

  // Switches feed operands directly; they only need metastability protection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw_raw;
      sw_s2 <= sw_s1;
    end
  end

  assign btnc = lvl[BTN_C];
  assign btnl = lvl[BTN_L];
  assign btnr = lvl[BTN_R];
  assign btnu = rise[BTN_U];
  assign btnd = rise[BTN_D];
  assign sw   = sw_s2;

  logic unused_btn;
  assign unused_btn = ^{lvl[BTN_U], lvl[BTN_D], rise[BTN_C], rise[BTN_L], rise[BTN_R]};

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner at DEBOUNCE_CYCLES=4: table vectors, directed
// corner sequences and random stimulus against a window-based reference model.
module tb_btn_conditioner;

  localparam int D  = 4;
  localparam int HL = D + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  braw = '0;   // {d, r, u, l, c}
  logic [15:0] sw_raw = '0;
  logic        btnc, btnl, btnr, btnu, btnd;
  logic [15:0] sw;

  int n_cmp = 0;
  int n_bad = 0;

  btn_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .btnc_raw(braw[0]), .btnl_raw(braw[1]), .btnu_raw(braw[2]),
    .btnr_raw(braw[3]), .btnd_raw(braw[4]),
    .sw_raw(sw_raw),
    .btnc(btnc), .btnl(btnl), .btnr(btnr), .btnu(btnu), .btnd(btnd),
    .sw(sw)
  );

  always #5 clk = ~clk;

  // Reference: history of raw values seen at each edge. A debounced level
  // flips when the synchronised input (raw from two edges back) has differed
  // from it on D consecutive edges.
  bit          mh[5][$];
  bit          mst[5];
  bit          mpulse[5];
  logic [15:0] swq[$];

  task automatic model_reset();
    for (int b = 0; b < 5; b++) begin
      mh[b] = {};
      for (int i = 0; i < HL; i++) mh[b].push_back(1'b0);
      mst[b] = 1'b0;
      mpulse[b] = 1'b0;
    end
    swq = {16'h0, 16'h0};
  endtask

  task automatic model_edge();
    for (int b = 0; b < 5; b++) begin
      bit old, all_diff;
      int n;
      mh[b].push_back(braw[b]);
      if (mh[b].size() > HL) void'(mh[b].pop_front());
      n = mh[b].size();
      old = mst[b];
      all_diff = 1'b1;
      for (int i = 0; i < D; i++)
        if (mh[b][n-3-i] == old) all_diff = 1'b0;
      if (all_diff) mst[b] = ~old;
      mpulse[b] = mst[b] & ~old;
    end
    swq.push_back(sw_raw);
    void'(swq.pop_front());
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model", {11'h0, btnc, btnl, btnr, btnu, btnd, sw},
        {11'h0, mst[0], mst[1], mst[3], mpulse[2], mpulse[4], swq[0]});
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [4:0]  braw;
    logic [15:0] swr;
    logic        exp_l;
    logic        exp_d;
    logic [15:0] exp_sw;
  } vec_t;

  vec_t tbl[30];

  initial begin
    int cnt, pos;

    for (int i = 0; i < 30; i++) begin
      tbl[i].braw   = {(i < 20) ? 1'b1 : 1'b0, 2'b00, (i < 10) ? 1'b1 : 1'b0, 1'b0};
      tbl[i].swr    = 16'h8001;
      tbl[i].exp_l  = (i >= 5 && i < 15);
      tbl[i].exp_d  = (i == 5);
      tbl[i].exp_sw = (i >= 1) ? 16'h8001 : 16'h0000;
    end

    // Power-up reset with every raw input high.
    #1 rst = 1'b1;
    braw = '1;
    sw_raw = 16'hFFFF;
    #1 chk("rst_assert", {11'h0, btnc, btnl, btnr, btnu, btnd, sw}, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold", {11'h0, btnc, btnl, btnr, btnu, btnd, sw}, 32'h0);
    end
    rst = 1'b0;
    model_reset();
    repeat (10) step();
    // Asynchronous assert between edges must clear outputs at once.
    #2 rst = 1'b1;
    #1 chk("rst_async", {11'h0, btnc, btnl, btnr, btnu, btnd, sw}, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_during", {11'h0, btnc, btnl, btnr, btnu, btnd, sw}, 32'h0);
    end
    braw = '0;
    sw_raw = '0;
    rst = 1'b0;
    model_reset();
    repeat (8) step();

    // Table: clean btnd press/release, btnl level, switch latency.
    rst_pulse();
    for (int i = 0; i < 30; i++) begin
      braw = tbl[i].braw;
      sw_raw = tbl[i].swr;
      step();
      chk($sformatf("tbl_l[%0d]", i), {31'h0, btnl}, {31'h0, tbl[i].exp_l});
      chk($sformatf("tbl_d[%0d]", i), {31'h0, btnd}, {31'h0, tbl[i].exp_d});
      chk($sformatf("tbl_sw[%0d]", i), {16'h0, sw}, {16'h0, tbl[i].exp_sw});
    end

    // Short btnu glitch never registers.
    rst_pulse();
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      braw[2] = (i < 3);
      step();
      if (btnu) cnt++;
    end
    chk("glitch_btnu_pulses", cnt, 0);

    // Bounce 1,0,1,0 then held: one pulse 5 edges after last transition.
    rst_pulse();
    cnt = 0; pos = -1;
    for (int i = 0; i < 16; i++) begin
      braw[2] = (i < 4) ? ((i % 2) == 0) : 1'b1;
      step();
      if (btnu) begin cnt++; pos = i; end
    end
    chk("bounce_btnu_pulses", cnt, 1);
    chk("bounce_btnu_pos", pos, 9);

    // 2-cycle dropout while btnl is held leaves the level high.
    rst_pulse();
    cnt = 0;
    for (int i = 0; i < 18; i++) begin
      braw[1] = !(i == 8 || i == 9);
      step();
      if (i >= 5 && !btnl) cnt++;
    end
    chk("dropout_btnl_lowcycles", cnt, 0);
    braw = '0;

    // Reset while btnd count is at 2; held through release.
    rst_pulse();
    braw[4] = 1'b1;
    repeat (4) step();
    #2 rst = 1'b1;
    #1 chk("midcnt_rst", {31'h0, btnd}, 32'h0);
    @(negedge clk);
    chk("midcnt_rst_hold", {31'h0, btnd}, 32'h0);
    rst = 1'b0;
    model_reset();
    cnt = 0; pos = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (btnd) begin cnt++; pos = i; end
    end
    chk("midcnt_pulses", cnt, 1);
    chk("midcnt_pos", pos, 6);
    braw = '0;

    // Simultaneous btnu/btnd press pulse together.
    rst_pulse();
    cnt = 0;
    braw[2] = 1'b1;
    braw[4] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (btnu && btnd) cnt++;
    end
    chk("simul_both_pulses", cnt, 1);
    braw = '0;

    // Random mix of bounces and stable runs across all buttons.
    rst_pulse();
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(3) == 0) braw[b] = ~braw[b];
      sw_raw = 16'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
